pa_cal_accum: RTL
=================

Name: pa_cal_accum

Overview:
- Upstream stage of the mean calculator.
- Accepts a framed stream of unsigned samples (valid/ready, last-marked) and accumulates their sum and sample count.
- At frame end it presents sum as dividend and count as divisor to the divider and pulses its start for one cycle.
- It then holds off new input until the divider reports done, so each mean result corresponds to exactly one frame.

Parameters:
- SIZE_DATA, 32, width of samples, running sum, count, and divider operands.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  sample valid.
- i_data  in  SIZE_DATA  unsigned sample.
- i_last  in  1  marks final sample of frame; qualified by i_valid.
- o_ready  out  1  block can accept a sample this cycle.
- i_clear  in  1  synchronous abort of the current frame.
- o_start  out  1  one-cycle start pulse to divider.
- o_dividend  out  SIZE_DATA  frame sum (mod 2^SIZE_DATA).
- o_divisor  out  SIZE_DATA  frame sample count.
- o_overflow  out  1  sum or count wrapped during the current/last frame.
- i_div_done  in  1  divider finished; result consumed downstream.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: clock i_clk; reset i_rst_n, asynchronous, active-low.
- Reset values: state IDLE, o_ready=1, o_start=0, o_dividend=0, o_divisor=1, o_overflow=0, o_busy=0. Reset applies from any state, including mid-frame or while waiting; the partial frame is discarded.
- Accept rule: a beat is accepted only when i_valid & o_ready are both high at a clock edge. Beats offered while o_ready=0 are ignored. Upstream must hold them; the block does not drop them silently.

FSM states (registered), o_ready and o_start are decoded from state:
- IDLE (o_ready=1, o_busy=0)
  - On accept: sum<=i_data, count<=1, overflow<=0.
  - Go to START if i_last, else ACC.
- ACC (o_ready=1)
  - On accept: sum<=sum+i_data, count<=count+1.
  - overflow<=1 on carry-out of sum or if count was all-ones (count wraps to 0). Overflow is sticky within the frame.
  - i_last on an accepted beat: go to START.
  - Cycles with i_valid=0 leave sum and count unchanged.
- START (o_ready=0)
  - o_start=1 for exactly this cycle.
  - o_dividend=sum and o_divisor=count, both valid in this cycle. Go to WAIT unconditionally.
- WAIT (o_ready=0)
  - o_dividend and o_divisor are held stable.
  - i_div_done sampled only here; on i_div_done go to IDLE.

Timing:
- Latency: last beat accepted at edge N, o_start high in cycle N+1.
- Earliest next-frame accept is the cycle after i_div_done is seen in WAIT.

Boundary conditions:
- Divisor is never 0 at START, except count wrap; in that case o_overflow=1 flags it.
- i_clear in ACC: return to IDLE and discard the frame. o_dividend and o_divisor keep their previous values; no o_start.
- i_clear in IDLE, START or WAIT: ignored.
- i_clear together with an accepted i_last in ACC: clear wins, no start.
- i_div_done in IDLE, ACC or START: ignored.
- o_overflow holds its value until the first beat of the next frame.

Test Plan:
- Frame 3,5,7 (last on 7), back-to-back beats -> o_start single pulse one cycle after last accept; o_dividend=15, o_divisor=3, o_overflow=0; o_ready=0 until i_div_done.
- Single-beat frame 42 with i_last -> dividend=42, divisor=1, o_start next cycle.
- Backpressure: present 9 with i_valid held during WAIT for 5 cycles, then pulse i_div_done -> o_ready rises the next cycle, 9 accepted then; new frame sum starts at 9, not accumulated onto the old sum.
- SIZE_DATA=8, frame 200,100 -> dividend=44, divisor=2, o_overflow=1. Next frame 1 (last) -> o_overflow=0, dividend=1.
- Frame 4, idle gap of 3 cycles, 6, i_clear asserted on beat 6 -> returns to IDLE, no o_start, outputs unchanged; following frame 10 (last) -> dividend=10, divisor=1.
- Assert i_rst_n low asynchronously mid-ACC and mid-WAIT -> all outputs immediately at reset values; after release a frame 2,2 gives dividend=4, divisor=2.

Source files
------------

// File: rtl/pa_cal_accum.sv
// Purpose : accumulates a framed stream of unsigned samples into sum/count and
//           hands them to the mean divider as dividend/divisor with a start pulse.
// Latency : last beat accepted at edge N -> o_start high during cycle N+1.
// Backpr. : o_ready drops from the start pulse until i_div_done is seen; upstream holds.
//
// Ports:
//   i_clk, i_rst_n              clock (rising edge), async active-low reset
//   i_valid/i_data/i_last       sample stream in, accepted when i_valid & o_ready
//   o_ready                     block can take a sample this cycle
//   i_clear                     synchronous abort of a frame in progress
//   o_start                     one-cycle divider kick
//   o_dividend/o_divisor        frame sum (mod 2^SIZE_DATA) / frame sample count
//   o_overflow                  sum or count wrapped in the current/last frame
//   i_div_done                  divider finished, result consumed
//   o_busy                      any state other than IDLE
module pa_cal_accum #(
  parameter int SIZE_DATA = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic [SIZE_DATA-1:0] i_data,
  input  logic                 i_last,
  output logic                 o_ready,
  input  logic                 i_clear,
  output logic                 o_start,
  output logic [SIZE_DATA-1:0] o_dividend,
  output logic [SIZE_DATA-1:0] o_divisor,
  output logic                 o_overflow,
  input  logic                 i_div_done,
  output logic                 o_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_START = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  localparam logic [SIZE_DATA-1:0] ONE = SIZE_DATA'(1);

  state_t               state_q, state_d;
  logic [SIZE_DATA-1:0] sum_q, count_q, dividend_q, divisor_q;
  logic                 ovf_q;

  logic                 accept;
  logic [SIZE_DATA:0]   sum_add;   // extra bit is the carry-out of the running sum
  logic [SIZE_DATA-1:0] count_inc;
  logic                 count_wrap;

  assign accept     = i_valid & o_ready;
  assign sum_add    = {1'b0, sum_q} + {1'b0, i_data};
  assign count_inc  = count_q + ONE;
  assign count_wrap = &count_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    o_ready = 1'b0;
    o_start = 1'b0;
    o_busy  = 1'b1;
    case (state_q)
      S_IDLE: begin
        o_ready = 1'b1;
        o_busy  = 1'b0;
        if (accept) state_d = i_last ? S_START : S_ACC;
      end
      S_ACC: begin
        o_ready = 1'b1;
        // Abort takes priority over a simultaneous last beat.
        if (i_clear)                state_d = S_IDLE;
        else if (accept && i_last)  state_d = S_START;
      end
      S_START: begin
        o_start = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_div_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Dividend/divisor are captured on the last accepted beat so they are already
  // valid in the START cycle and stay frozen through WAIT and any aborted frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sum_q      <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= ONE;
    end else begin
      if (state_q == S_IDLE && accept) begin
        sum_q   <= i_data;
        count_q <= ONE;
        ovf_q   <= 1'b0;
        if (i_last) begin
          dividend_q <= i_data;
          divisor_q  <= ONE;
        end
      end else if (state_q == S_ACC && !i_clear && accept) begin
        sum_q   <= sum_add[SIZE_DATA-1:0];
        count_q <= count_inc;
        ovf_q   <= ovf_q | sum_add[SIZE_DATA] | count_wrap;
        if (i_last) begin
          dividend_q <= sum_add[SIZE_DATA-1:0];
          divisor_q  <= count_inc;
        end
      end
    end
  end

  assign o_dividend = dividend_q;
  assign o_divisor  = divisor_q;
  assign o_overflow = ovf_q;

endmodule
